spi_host_ctrl: RTL and testbench

Host-side SPI initiator for the PSEC5 digital configuration port. It serializes an address byte followed by write-data bytes onto the peripheral's `serial_in` line and deserializes the peripheral's `serial_out` readback into bytes. It gates the peripheral clock so that a stopped `sclk` terminates each frame. It sits in the test/FPGA controller between a byte-stream command interface and the chip's SPI pins.

---
 rtl/spi_host_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_spi_host_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl
// Host-side SPI initiator for the PSEC5 configuration port.
// A command carries a start address and a byte count. The frame sent is the
// address byte, then the write bytes, LSB first. Readback bytes from miso are
// assembled into rd_data. The peripheral clock is gated off between frames so
// that the peripheral can detect the end of each frame.
//
// Optional build macro: SPI_HOST_CTRL_LOOPBACK_EN
//   Adds the input loopback_en. When it is high, the read shifter samples
//   mosi delayed by RD_LATENCY flops and ignores the miso pin.
//
// Ports
//   sclk, rstn        free-running bit clock; asynchronous active-low reset
//   cmd_valid/ready   command handshake. cmd_ready is high only in IDLE.
//   cmd_addr, cmd_len start address and data byte count (clamped to MAX_BYTES)
//   wr_data/_valid    next write byte
//   wr_data_ready     pulse: wr_data is consumed on this cycle
//   rd_data/_valid    assembled readback byte, one pulse per data byte
//   sclk_en           enable for the external clock gate
//   mosi, miso        serial pins
//   busy, frame_done  frame in progress; pulse on the last GAP cycle
//   wr_underflow      sticky: a write byte was missing (0x00 sent instead)
//
// Handshake: a command is taken on a rising edge with cmd_valid && cmd_ready.
// A write byte is taken on a rising edge with wr_data_ready high. If
// wr_data_valid is low on that edge, 0x00 is sent instead.
module spi_host_ctrl #(
    parameter  int MAX_BYTES  = 8,
    parameter  int RD_LATENCY = 1,
    parameter  int GAP_CYCLES = 4,
    localparam int LW         = $clog2(MAX_BYTES + 1)
) (
    input  logic          sclk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [7:0]    wr_data,
    input  logic          wr_data_valid,
    output logic          wr_data_ready,
    output logic [7:0]    rd_data,
    output logic          rd_data_valid,
    output logic          sclk_en,
    output logic          mosi,
`ifdef SPI_HOST_CTRL_LOOPBACK_EN
    input  logic          loopback_en,
`endif
    input  logic          miso,
    output logic          busy,
    output logic          frame_done,
    output logic          wr_underflow
);

    // The counter spans the whole active part of a frame (ADDR+DATA+TAIL).
    // It is reused for GAP.
    localparam int CW = $clog2(8 * MAX_BYTES + RD_LATENCY + GAP_CYCLES + 9);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_TAIL, S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          uf_q, uf_d;

    logic [CW-1:0] data_last;    // count on the last cycle of DATA (or ADDR when len=0)
    logic [CW-1:0] active_last;  // count on the last cycle of TAIL
    logic [CW-1:0] cap_first;    // first count at which a read bit is sampled
    logic [2:0]    cap_bit;      // bit position of the read bit being sampled
    logic          shifting;     // ADDR or DATA: a real bit is on mosi
    logic          active;
    logic          miso_s;

    assign data_last   = CW'({len_q, 3'b111});
    assign active_last = data_last + CW'(RD_LATENCY);
    assign cap_first   = CW'(8 + RD_LATENCY);
    assign cap_bit     = cnt_q[2:0] - 3'(8 + RD_LATENCY);
    assign shifting    = (state_q == S_ADDR) || (state_q == S_DATA);
    assign active      = shifting || (state_q == S_TAIL);

    // The ADDR and DATA bytes line up with multiples of 8 on the counter.
    // This gives two things: the low 3 bits select the bit to send, and
    // cnt>>3 is the number of bytes already started.
    assign mosi          = shifting ? tx_q[cnt_q[2:0]] : 1'b0;
    assign wr_data_ready = shifting && (cnt_q[2:0] == 3'd7) && ((cnt_q >> 3) < CW'(len_q));
    assign sclk_en       = active;
    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = (state_q == S_GAP) && (cnt_q == CW'(GAP_CYCLES - 1));
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign wr_underflow  = uf_q;

`ifdef SPI_HOST_CTRL_LOOPBACK_EN
    localparam int LBW = RD_LATENCY;
    logic [LBW-1:0] lb_q, lb_d;

    // mosi delayed by RD_LATENCY cycles. This matches the timing of the
    // peripheral's serial_out path.
    always_comb begin
        lb_d = (lb_q << 1) | LBW'(mosi);
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) lb_q <= '0;
        else       lb_q <= lb_d;
    end

    assign miso_s = loopback_en ? lb_q[LBW-1] : miso;
`else
    assign miso_s = miso;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        uf_d       = uf_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    len_d   = (cmd_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : cmd_len;
                    tx_d    = cmd_addr;
                    uf_d    = 1'b0;
                end
            end
            S_ADDR, S_DATA, S_TAIL: begin
                cnt_d = cnt_q + 1'b1;
                // Test active_last first: with RD_LATENCY=0 it is equal to data_last.
                if (cnt_q == active_last) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == data_last) begin
                    state_d = S_TAIL;
                end else if (cnt_q == CW'(7)) begin
                    state_d = S_DATA;
                end

                if (wr_data_ready) begin
                    tx_d = wr_data_valid ? wr_data : 8'h00;
                    if (!wr_data_valid) uf_d = 1'b1;
                end

                // Read bits arrive RD_LATENCY cycles after their launch slot.
                // For that reason, sampling continues through TAIL.
                if (cnt_q >= cap_first) begin
                    rx_d = {miso_s, rx_q[7:1]};
                    if (cap_bit == 3'd7) begin
                        rd_data_d  = rx_d;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (frame_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            uf_q       <= uf_d;
        end
    end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Testbench for spi_host_ctrl. A peripheral model returns bytes from a
// 256-entry memory, using the address it decodes from mosi. A driver issues
// commands and pushes the expected results onto queues. Separate monitors
// pop those queues and compare them against rd_data_valid and frame_done.
module tb_spi_host_ctrl;

    localparam int MAX_BYTES  = 8;
    localparam int RD_LATENCY = 1;
    localparam int GAP_CYCLES = 4;
    localparam int LW         = $clog2(MAX_BYTES + 1);

    logic          sclk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_data_valid = 1'b0;
    logic          wr_data_ready;
    logic [7:0]    rd_data;
    logic          rd_data_valid;
    logic          sclk_en;
    logic          mosi;
    logic          miso = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          wr_underflow;
`ifdef SPI_HOST_CTRL_LOOPBACK_EN
    logic          loopback_en = 1'b0;
`endif

    spi_host_ctrl #(
        .MAX_BYTES (MAX_BYTES),
        .RD_LATENCY(RD_LATENCY),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .sclk         (sclk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_data      (wr_data),
        .wr_data_valid(wr_data_valid),
        .wr_data_ready(wr_data_ready),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .sclk_en      (sclk_en),
        .mosi         (mosi),
`ifdef SPI_HOST_CTRL_LOOPBACK_EN
        .loopback_en  (loopback_en),
`endif
        .miso         (miso),
        .busy         (busy),
        .frame_done   (frame_done),
        .wr_underflow (wr_underflow)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check bookkeeping ----------------
    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- scoreboard state ----------------
    typedef struct {
        int          len;
        logic [79:0] bits;      // address byte followed by data bytes, bit k = k-th bit sent
        logic        uf;
        int          done_cyc;
    } frame_t;

    logic [7:0] exp_rd_q[$];
    int         exp_rd_cyc_q[$];
    frame_t     exp_frame_q[$];
    logic [7:0] mem [256];
    bit         lb_mode = 1'b0;

    // ---------------- peripheral model ----------------
    // It counts the clocks it receives. The first 8 clocks carry the address.
    // Data bit i of byte j is returned so that it is valid RD_LATENCY clocks
    // after its own launch slot.
    int         p_n = 0;
    logic [7:0] p_addr = '0;
    always @(negedge sclk) begin
        int         idx;
        logic [7:0] b;
        if (!rstn || !sclk_en) begin
            p_n  = 0;
            miso = 1'($urandom_range(0, 1));
        end else begin
            if (p_n < 8) p_addr[p_n] = mosi;
            if (p_n >= 8 + RD_LATENCY) begin
                idx  = p_n - 8 - RD_LATENCY;
                b    = mem[p_addr + 8'(idx / 8)];
                miso = b[idx % 8];
            end else begin
                miso = 1'($urandom_range(0, 1));
            end
            p_n++;
        end
    end

    // ---------------- monitors ----------------
    always @(negedge sclk) begin
        if (rstn && rd_data_valid) begin
            if (exp_rd_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
                check("rd_cycle", cyc, exp_rd_cyc_q.pop_front());
            end
        end
    end

    int          m_n = 0;
    logic [127:0] m_bits = '0;
    frame_t      m_f;
    int          m_tail;
    always @(negedge sclk) begin
        if (!rstn) begin
            m_n = 0;
        end else begin
            if (sclk_en) begin
                m_bits[m_n] = mosi;
                m_n++;
            end
            if (frame_done) begin
                if (exp_frame_q.size() == 0) begin
                    check("frame_unexpected", 32'd1, 32'd0);
                end else begin
                    m_f = exp_frame_q.pop_front();
                    check("sclk_en_cycles", m_n, 8 + 8 * m_f.len + RD_LATENCY);
                    for (int b = 0; b <= m_f.len; b++)
                        check($sformatf("mosi_byte%0d", b), 32'(m_bits[b*8 +: 8]), 32'(m_f.bits[b*8 +: 8]));
                    m_tail = 0;
                    for (int k = 0; k < RD_LATENCY; k++) m_tail += int'(m_bits[8 + 8 * m_f.len + k]);
                    check("mosi_tail_ones", m_tail, 0);
                    check("frame_done_cycle", cyc, m_f.done_cyc);
                    check("wr_underflow", 32'(wr_underflow), 32'(m_f.uf));
                end
                m_n = 0;
            end
        end
    end

    // ---------------- driver ----------------
    // abort_at > 0: reset is asserted at that cycle offset from the accept edge.
    task automatic run_frame(input logic [7:0] addr, input int len_req,
                             input logic [63:0] data, input bit uf, input int abort_at);
        int     el, a, idx, budget;
        bit     pend;
        frame_t f;
        budget = 0;
        @(negedge sclk);
        while (!cmd_ready && budget < 300) begin
            @(negedge sclk);
            budget++;
        end
        el            = (len_req > MAX_BYTES) ? MAX_BYTES : len_req;
        cmd_addr      = addr;
        cmd_len       = LW'(len_req);
        wr_data       = data[7:0];
        wr_data_valid = !uf;
        cmd_valid     = 1'b1;
        @(posedge sclk);
        #1;
        a         = cyc;
        cmd_valid = 1'b0;
        check("uf_clear_on_accept", 32'(wr_underflow), 32'd0);
        check("busy_after_accept", 32'(busy), 32'd1);

        f.len  = el;
        f.bits = '0;
        f.bits[7:0] = addr;
        for (int j = 0; j < el; j++) f.bits[8 + 8*j +: 8] = uf ? 8'h00 : data[8*j +: 8];
        f.uf       = uf;
        f.done_cyc = a + 7 + 8 * el + RD_LATENCY + GAP_CYCLES;
        exp_frame_q.push_back(f);
        for (int j = 0; j < el; j++) begin
            exp_rd_q.push_back(lb_mode ? f.bits[8 + 8*j +: 8] : mem[addr + 8'(j)]);
            exp_rd_cyc_q.push_back(a + 16 + 8 * j + RD_LATENCY);
        end

        idx    = 0;
        pend   = 1'b0;
        budget = 0;
        do begin
            @(negedge sclk);
            budget++;
            if (abort_at > 0 && cyc == a + abort_at) begin
                #2 rstn = 1'b0;
                #1;
                check("abort_sclk_en", 32'(sclk_en), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
                check("abort_mosi", 32'(mosi), 32'd0);
                exp_rd_q.delete();
                exp_rd_cyc_q.delete();
                exp_frame_q.delete();
                wr_data_valid = 1'b0;
                @(negedge sclk);
                @(negedge sclk);
                #2 rstn = 1'b1;
                return;
            end
            if (pend && idx < 7) begin
                idx++;
                wr_data = data[idx*8 +: 8];
            end
            pend = 1'b0;
            if (wr_data_ready) pend = 1'b1;
        end while (!cmd_ready && budget < 200);
        check("cmd_ready_cycle", cyc, a + 8 + 8 * el + RD_LATENCY + GAP_CYCLES);
        wr_data_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          len;
        logic [63:0] d;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h3D] = 8'hA5;
        mem[8'h3E] = 8'h5A;
        mem[8'h3F] = 8'hFF;

        repeat (3) @(negedge sclk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_sclk_en", 32'(sclk_en), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_pulses", 32'({rd_data_valid, frame_done, wr_data_ready, wr_underflow}), 32'd0);
        #2 rstn = 1'b1;
        @(negedge sclk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_sclk_en", 32'(sclk_en), 32'd0);

        run_frame(8'h02, 1, 64'h03, 1'b0, 0);
        run_frame(8'h3D, 3, {$urandom, $urandom}, 1'b0, 0);
        run_frame(8'h10, 2, {$urandom, $urandom}, 1'b1, 0);
        run_frame(8'($urandom), 15, {$urandom, $urandom}, 1'b0, 0);
        run_frame(8'($urandom), 2, {$urandom, $urandom}, 1'b0, 19);
        run_frame(8'($urandom), 1, {$urandom, $urandom}, 1'b0, 0);
`ifdef SPI_HOST_CTRL_LOOPBACK_EN
        lb_mode     = 1'b1;
        loopback_en = 1'b1;
        run_frame(8'h55, 1, 64'hC3, 1'b0, 0);
        run_frame(8'($urandom), 4, {$urandom, $urandom}, 1'b0, 0);
        lb_mode     = 1'b0;
        loopback_en = 1'b0;
`endif
        for (int n = 0; n < 20; n++) begin
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(MAX_BYTES + 1, 15)
                                              : $urandom_range(1, MAX_BYTES);
            d   = {$urandom, $urandom};
            run_frame(8'($urandom), len, d, $urandom_range(0, 5) == 0, 0);
        end

        repeat (4) @(negedge sclk);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("frame_queue_drained", exp_frame_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
